// File: rtl/id_decode_stage.sv
// id_decode_stage: one-cycle registered MIPS32 decode (ANDI/ORI/XORI/LUI, SPECIAL logic/shifts, BEQ/BNE/J).
// Define ID_FORWARD_EN for EX/MEM forwarding with load-use stalls; otherwise interlock on any pending writer.

`ifndef ALU_NOP
`define ALU_NOP 0
`define ALU_AND 1
`define ALU_OR  2
`define ALU_XOR 3
`define ALU_NOR 4
`define ALU_SLL 5
`define ALU_SRL 6
`define ALU_SRA 7
`endif

module id_decode_stage #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        inst_i,
  input  logic [31:0]        pc_i,
  output logic [REG_AW-1:0]  rf_raddr1_o,
  output logic [REG_AW-1:0]  rf_raddr2_o,
  input  logic [DATA_W-1:0]  rf_rdata1_i,
  input  logic [DATA_W-1:0]  rf_rdata2_i,
  input  logic               ex_wen_i,
  input  logic [REG_AW-1:0]  ex_waddr_i,
  input  logic [DATA_W-1:0]  ex_wdata_i,
  input  logic               ex_is_load_i,
  input  logic               mem_wen_i,
  input  logic [REG_AW-1:0]  mem_waddr_i,
  input  logic [DATA_W-1:0]  mem_wdata_i,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  op1_o,
  output logic [DATA_W-1:0]  op2_o,
  output logic [ALUOP_W-1:0] alu_op_o,
  output logic               wen_o,
  output logic [REG_AW-1:0]  waddr_o,
  output logic               branch_en_o,
  output logic [31:0]        branch_addr_o,
  output logic               inst_invalid_o
);

  localparam logic [5:0] OP_SPECIAL = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05,
                         OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_XORI = 6'h0E, OP_LUI = 6'h0F;
  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03, FN_SLLV = 6'h04,
                         FN_SRLV = 6'h06, FN_SRAV = 6'h07, FN_AND = 6'h24, FN_OR = 6'h25,
                         FN_XOR = 6'h26, FN_NOR = 6'h27;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [25:0] idx;

  assign opcode = inst_i[31:26];
  assign rs     = inst_i[25:21];
  assign rt     = inst_i[20:16];
  assign rd     = inst_i[15:11];
  assign shamt  = inst_i[10:6];
  assign funct  = inst_i[5:0];
  assign imm    = inst_i[15:0];
  assign idx    = inst_i[25:0];

  logic               use_rs, use_rt, is_beq, is_bne, is_j;
  logic               wen_d, invalid_d;
  logic [REG_AW-1:0]  waddr_d;
  logic [ALUOP_W-1:0] alu_d;
  logic [DATA_W-1:0]  op1_imm, op2_imm;

  always_comb begin
    use_rs    = 1'b0;
    use_rt    = 1'b0;
    is_beq    = 1'b0;
    is_bne    = 1'b0;
    is_j      = 1'b0;
    wen_d     = 1'b0;
    invalid_d = 1'b0;
    waddr_d   = '0;
    alu_d     = ALUOP_W'(`ALU_NOP);
    op1_imm   = '0;
    op2_imm   = '0;
    case (opcode)
      OP_SPECIAL: begin
        use_rt  = 1'b1;
        wen_d   = 1'b1;
        waddr_d = REG_AW'(rd);
        case (funct)
          FN_AND:  begin use_rs = 1'b1; alu_d = ALUOP_W'(`ALU_AND); end
          FN_OR:   begin use_rs = 1'b1; alu_d = ALUOP_W'(`ALU_OR);  end
          FN_XOR:  begin use_rs = 1'b1; alu_d = ALUOP_W'(`ALU_XOR); end
          FN_NOR:  begin use_rs = 1'b1; alu_d = ALUOP_W'(`ALU_NOR); end
          FN_SLLV: begin use_rs = 1'b1; alu_d = ALUOP_W'(`ALU_SLL); end
          FN_SRLV: begin use_rs = 1'b1; alu_d = ALUOP_W'(`ALU_SRL); end
          FN_SRAV: begin use_rs = 1'b1; alu_d = ALUOP_W'(`ALU_SRA); end
          FN_SLL:  begin op1_imm = DATA_W'(shamt); alu_d = ALUOP_W'(`ALU_SLL); end
          FN_SRL:  begin op1_imm = DATA_W'(shamt); alu_d = ALUOP_W'(`ALU_SRL); end
          FN_SRA:  begin op1_imm = DATA_W'(shamt); alu_d = ALUOP_W'(`ALU_SRA); end
          default: begin
            use_rt    = 1'b0;
            wen_d     = 1'b0;
            waddr_d   = '0;
            invalid_d = 1'b1;
          end
        endcase
      end
      OP_J:   is_j = 1'b1;
      OP_BEQ: begin use_rs = 1'b1; use_rt = 1'b1; is_beq = 1'b1; end
      OP_BNE: begin use_rs = 1'b1; use_rt = 1'b1; is_bne = 1'b1; end
      OP_ANDI, OP_ORI, OP_XORI: begin
        use_rs  = 1'b1;
        wen_d   = 1'b1;
        waddr_d = REG_AW'(rt);
        op2_imm = DATA_W'(imm);
        alu_d   = (opcode == OP_ANDI) ? ALUOP_W'(`ALU_AND) :
                  (opcode == OP_ORI)  ? ALUOP_W'(`ALU_OR)  : ALUOP_W'(`ALU_XOR);
      end
      OP_LUI: begin
        wen_d   = 1'b1;
        waddr_d = REG_AW'(rt);
        op2_imm = DATA_W'({imm, 16'h0000});
        alu_d   = ALUOP_W'(`ALU_OR);
      end
      default: invalid_d = 1'b1;
    endcase
  end

  // Unread fields present address 0 so they can never match a pending writer.
  assign rf_raddr1_o = use_rs ? REG_AW'(rs) : '0;
  assign rf_raddr2_o = use_rt ? REG_AW'(rt) : '0;

  logic ex_hit1, ex_hit2, mem_hit1, mem_hit2, stall;
  assign ex_hit1  = ex_wen_i  && (ex_waddr_i  != '0) && (ex_waddr_i  == rf_raddr1_o);
  assign ex_hit2  = ex_wen_i  && (ex_waddr_i  != '0) && (ex_waddr_i  == rf_raddr2_o);
  assign mem_hit1 = mem_wen_i && (mem_waddr_i != '0) && (mem_waddr_i == rf_raddr1_o);
  assign mem_hit2 = mem_wen_i && (mem_waddr_i != '0) && (mem_waddr_i == rf_raddr2_o);

  logic [DATA_W-1:0] src1, src2;
`ifdef ID_FORWARD_EN
  always_comb begin
    if (rf_raddr1_o == '0)  src1 = '0;
    else if (ex_hit1)       src1 = ex_wdata_i;
    else if (mem_hit1)      src1 = mem_wdata_i;
    else                    src1 = rf_rdata1_i;
    if (rf_raddr2_o == '0)  src2 = '0;
    else if (ex_hit2)       src2 = ex_wdata_i;
    else if (mem_hit2)      src2 = mem_wdata_i;
    else                    src2 = rf_rdata2_i;
  end
  assign stall = ex_is_load_i && (ex_hit1 || ex_hit2);
`else
  assign src1  = (rf_raddr1_o == '0) ? '0 : rf_rdata1_i;
  assign src2  = (rf_raddr2_o == '0) ? '0 : rf_rdata2_i;
  assign stall = ex_hit1 || ex_hit2 || mem_hit1 || mem_hit2;
  logic unused_fwd;
  assign unused_fwd = ^{ex_wdata_i, mem_wdata_i, ex_is_load_i};
`endif

  logic [31:0] pc4, br_target, j_target, baddr_d;
  logic        taken_d;
  assign pc4       = pc_i + 32'd4;
  assign br_target = pc4 + {{14{imm[15]}}, imm, 2'b00};
  assign j_target  = {pc4[31:28], idx, 2'b00};
  assign baddr_d   = is_j ? j_target : ((is_beq || is_bne) ? br_target : 32'h0);
  assign taken_d   = is_j || (is_beq && (src1 == src2)) || (is_bne && (src1 != src2));

  logic [DATA_W-1:0] op1_d, op2_d;
  assign op1_d = use_rs ? src1 : op1_imm;
  assign op2_d = use_rt ? src2 : op2_imm;

  logic               out_valid_q, wen_q, branch_en_q, invalid_q, accept;
  logic [DATA_W-1:0]  op1_q, op2_q;
  logic [ALUOP_W-1:0] alu_q;
  logic [REG_AW-1:0]  waddr_q;
  logic [31:0]        baddr_q;

  assign in_ready = !rst && (!out_valid_q || out_ready) && !stall;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      op1_q       <= '0;
      op2_q       <= '0;
      alu_q       <= '0;
      wen_q       <= 1'b0;
      waddr_q     <= '0;
      branch_en_q <= 1'b0;
      baddr_q     <= '0;
      invalid_q   <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      alu_q       <= alu_d;
      wen_q       <= wen_d;
      waddr_q     <= waddr_d;
      branch_en_q <= taken_d;
      baddr_q     <= baddr_d;
      invalid_q   <= invalid_d;
    end else if (out_ready) begin
      // Redirect must not outlive its packet.
      out_valid_q <= 1'b0;
      branch_en_q <= 1'b0;
    end
  end

  assign out_valid      = out_valid_q;
  assign op1_o          = op1_q;
  assign op2_o          = op2_q;
  assign alu_op_o       = alu_q;
  assign wen_o          = wen_q;
  assign waddr_o        = waddr_q;
  assign branch_en_o    = branch_en_q;
  assign branch_addr_o  = baddr_q;
  assign inst_invalid_o = invalid_q;

endmodule

// File: tb/tb_id_decode_stage.sv
// Directed bench for id_decode_stage: decode table plus hazard, back-pressure and reset sequences.
// Expectations follow ID_FORWARD_EN, so the bench builds with or without it.
module tb_id_decode_stage;
  localparam int ALU_NOP = 0, ALU_AND = 1, ALU_OR = 2, ALU_XOR = 3, ALU_NOR = 4,
                 ALU_SLL = 5, ALU_SRL = 6, ALU_SRA = 7;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] inst, pc;
  logic [4:0]  raddr1, raddr2, ex_waddr, mem_waddr, waddr;
  logic [31:0] rf1, rf2, ex_wdata, mem_wdata, op1, op2, baddr;
  logic        ex_wen, ex_is_load, mem_wen, wen, br, inv;
  logic [4:0]  alu;

  id_decode_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .inst_i(inst), .pc_i(pc),
    .rf_raddr1_o(raddr1), .rf_raddr2_o(raddr2), .rf_rdata1_i(rf1), .rf_rdata2_i(rf2),
    .ex_wen_i(ex_wen), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata), .ex_is_load_i(ex_is_load),
    .mem_wen_i(mem_wen), .mem_waddr_i(mem_waddr), .mem_wdata_i(mem_wdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .op1_o(op1), .op2_o(op2), .alu_op_o(alu), .wen_o(wen), .waddr_o(waddr),
    .branch_en_o(br), .branch_addr_o(baddr), .inst_invalid_o(inv)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] inst, pc, rf1, rf2, op1, op2;
    int          alu;
    logic        wen;
    logic [4:0]  waddr;
    logic        br;
    logic [31:0] baddr;
    logic        inv, chk_ops, chk_ba;
  } vec_t;

  vec_t vt[13];

  initial begin
    //        inst          pc            rf1           rf2           op1           op2           alu      wen   waddr br    baddr         inv   ops   ba
    vt[0]  = '{32'h34011234, 32'h0,        32'hDEADBEEF, 32'h0,        32'h0,        32'h00001234, ALU_OR,  1'b1, 5'd1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0};
    vt[1]  = '{32'h30228001, 32'h0,        32'hFFFFFFFF, 32'h0,        32'hFFFFFFFF, 32'h00008001, ALU_AND, 1'b1, 5'd2, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0};
    vt[2]  = '{32'h3867FFFF, 32'h0,        32'h12345678, 32'h0,        32'h12345678, 32'h0000FFFF, ALU_XOR, 1'b1, 5'd7, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0};
    vt[3]  = '{32'h3C09ABCD, 32'h0,        32'h00000077, 32'h0,        32'h0,        32'hABCD0000, ALU_OR,  1'b1, 5'd9, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0};
    vt[4]  = '{32'h00A62027, 32'h0,        32'hAAAA0000, 32'h0000BBBB, 32'hAAAA0000, 32'h0000BBBB, ALU_NOR, 1'b1, 5'd4, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0};
    vt[5]  = '{32'h000941C3, 32'h0,        32'h00005555, 32'h80000000, 32'h7,        32'h80000000, ALU_SRA, 1'b1, 5'd8, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0};
    vt[6]  = '{32'h018B5006, 32'h0,        32'h4,        32'hF0,       32'h4,        32'hF0,       ALU_SRL, 1'b1, 5'd10,1'b0, 32'h0,        1'b0, 1'b1, 1'b0};
    vt[7]  = '{32'h1022FFFF, 32'h100,      32'h55,       32'h55,       32'h55,       32'h55,       ALU_NOP, 1'b0, 5'd0, 1'b1, 32'h100,      1'b0, 1'b1, 1'b1};
    vt[8]  = '{32'h1022FFFF, 32'h100,      32'h55,       32'h56,       32'h55,       32'h56,       ALU_NOP, 1'b0, 5'd0, 1'b0, 32'h100,      1'b0, 1'b1, 1'b1};
    vt[9]  = '{32'h14640002, 32'h2000,     32'h1,        32'h2,        32'h1,        32'h2,        ALU_NOP, 1'b0, 5'd0, 1'b1, 32'h200C,     1'b0, 1'b1, 1'b1};
    vt[10] = '{32'h08123456, 32'hA0000000, 32'h99,       32'h99,       32'h0,        32'h0,        ALU_NOP, 1'b0, 5'd0, 1'b1, 32'hA048D158, 1'b0, 1'b0, 1'b1};
    vt[11] = '{32'hFC221234, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        ALU_NOP, 1'b0, 5'd0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0};
    vt[12] = '{32'h0022183F, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        ALU_NOP, 1'b0, 5'd0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; inst = 32'h34011234; pc = 32'h0;
    rf1 = 32'h0; rf2 = 32'h0; ex_wen = 1'b0; ex_waddr = 5'd0; ex_wdata = 32'h0; ex_is_load = 1'b0;
    mem_wen = 1'b0; mem_waddr = 5'd0; mem_wdata = 32'h0;

    // Reset state
    tick(); tick();
    chk("rst.in_ready", in_ready, 0);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.op1", op1, 0);
    chk("rst.op2", op2, 0);
    chk("rst.alu", alu, 0);
    chk("rst.wen", wen, 0);
    chk("rst.waddr", waddr, 0);
    chk("rst.br", br, 0);
    chk("rst.baddr", baddr, 0);
    chk("rst.inv", inv, 0);
    rst = 1'b0; in_valid = 1'b0;
    tick();
    chk("idle.out_valid", out_valid, 0);

    // Decode table, back-to-back at full rate
    for (int i = 0; i < 13; i++) begin
      inst = vt[i].inst; pc = vt[i].pc; rf1 = vt[i].rf1; rf2 = vt[i].rf2; in_valid = 1'b1;
      #1;
      chk($sformatf("v%0d.in_ready", i), in_ready, 1);
      tick();
      chk($sformatf("v%0d.out_valid", i), out_valid, 1);
      chk($sformatf("v%0d.wen", i), wen, vt[i].wen);
      chk($sformatf("v%0d.br", i), br, vt[i].br);
      chk($sformatf("v%0d.inv", i), inv, vt[i].inv);
      if (vt[i].wen || vt[i].inv) chk($sformatf("v%0d.alu", i), alu, vt[i].alu);
      if (vt[i].wen) chk($sformatf("v%0d.waddr", i), waddr, vt[i].waddr);
      if (vt[i].chk_ops) begin
        chk($sformatf("v%0d.op1", i), op1, vt[i].op1);
        chk($sformatf("v%0d.op2", i), op2, vt[i].op2);
      end
      if (vt[i].chk_ba) chk($sformatf("v%0d.baddr", i), baddr, vt[i].baddr);
    end

    // Taken branch, then bubble: branch_en must drop with out_valid
    inst = 32'h1022FFFF; pc = 32'h100; rf1 = 32'h9; rf2 = 32'h9;
    tick();
    chk("brk.br", br, 1);
    in_valid = 1'b0;
    tick();
    chk("brk.out_valid_drop", out_valid, 0);
    chk("brk.br_drop", br, 0);

    // AND $3,$1,$2 with EX writing $1 and MEM writing $2
    inst = 32'h00221824; pc = 32'h0; in_valid = 1'b1; rf1 = 32'hDEAD; rf2 = 32'hBEEF;
    ex_wen = 1'b1; ex_waddr = 5'd1; ex_wdata = 32'hFF00;
    mem_wen = 1'b1; mem_waddr = 5'd2; mem_wdata = 32'h0F0F;
    #1;
    chk("fwd.raddr1", raddr1, 1);
    chk("fwd.raddr2", raddr2, 2);
`ifdef ID_FORWARD_EN
    chk("fwd.in_ready", in_ready, 1);
    tick();
    chk("fwd.out_valid", out_valid, 1);
    chk("fwd.op1", op1, 32'hFF00);
    chk("fwd.op2", op2, 32'h0F0F);
    chk("fwd.waddr", waddr, 3);
    chk("fwd.alu", alu, ALU_AND);
`else
    chk("ilk.in_ready0", in_ready, 0);
    tick();
    chk("ilk.out_valid0", out_valid, 0);
    ex_wen = 1'b0;
    #1;
    chk("ilk.in_ready_mem", in_ready, 0);
    tick();
    chk("ilk.out_valid1", out_valid, 0);
    mem_wen = 1'b0; rf1 = 32'h1111; rf2 = 32'h2222;
    #1;
    chk("ilk.in_ready_clr", in_ready, 1);
    tick();
    chk("ilk.out_valid", out_valid, 1);
    chk("ilk.op1", op1, 32'h1111);
    chk("ilk.op2", op2, 32'h2222);
`endif
    in_valid = 1'b0; ex_wen = 1'b0; mem_wen = 1'b0;
    tick();

    // Load-use: EX loads $4, next is OR $5,$4,$0
    inst = 32'h00802825; in_valid = 1'b1; rf1 = 32'h0; rf2 = 32'h1234;
    ex_wen = 1'b1; ex_is_load = 1'b1; ex_waddr = 5'd4; ex_wdata = 32'hBAD;
    #1;
    chk("lu.in_ready0", in_ready, 0);
    tick();
    chk("lu.out_valid0", out_valid, 0);
    ex_wen = 1'b0; ex_is_load = 1'b0; mem_wen = 1'b1; mem_waddr = 5'd4; mem_wdata = 32'hCAFE;
`ifndef ID_FORWARD_EN
    #1;
    chk("lu.in_ready_mem", in_ready, 0);
    tick();
    mem_wen = 1'b0; rf1 = 32'hCAFE;
`endif
    #1;
    chk("lu.in_ready1", in_ready, 1);
    tick();
    chk("lu.out_valid", out_valid, 1);
    chk("lu.op1", op1, 32'hCAFE);
    chk("lu.op2", op2, 0);
    chk("lu.waddr", waddr, 5);
    mem_wen = 1'b0;

    // EX back-pressure for 3 cycles with the next instruction waiting
    inst = 32'h34011234; rf1 = 32'h0;
    tick();
    inst = 32'h3867FFFF; rf1 = 32'h10; out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp%0d.in_ready", c), in_ready, 0);
      tick();
      chk($sformatf("bp%0d.out_valid", c), out_valid, 1);
      chk($sformatf("bp%0d.op2", c), op2, 32'h1234);
      chk($sformatf("bp%0d.waddr", c), waddr, 1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp.in_ready_rel", in_ready, 1);
    tick();
    chk("bp.op1", op1, 32'h10);
    chk("bp.op2", op2, 32'hFFFF);
    chk("bp.waddr", waddr, 7);
    in_valid = 1'b0;
    tick();
    chk("bp.no_dup", out_valid, 0);

    // Stall and back-pressure together
    in_valid = 1'b1; inst = 32'h34011234; rf1 = 32'h0;
    tick();
    out_ready = 1'b0; inst = 32'h00802825;
    ex_wen = 1'b1; ex_is_load = 1'b1; ex_waddr = 5'd4;
    tick();
    chk("sb.hold_valid", out_valid, 1);
    chk("sb.hold_op2", op2, 32'h1234);
    out_ready = 1'b1;
    #1;
    chk("sb.in_ready", in_ready, 0);
    tick();
    chk("sb.drain", out_valid, 0);
    ex_wen = 1'b0; ex_is_load = 1'b0; rf1 = 32'hCAFE;
    tick();
    chk("sb.out_valid", out_valid, 1);
    chk("sb.op1", op1, 32'hCAFE);
    in_valid = 1'b0;
    tick();
    chk("sb.single", out_valid, 0);

    // Reset with a held packet discards it
    in_valid = 1'b1; inst = 32'h34011234; out_ready = 1'b0;
    tick();
    chk("rr.pre_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("rr.in_ready", in_ready, 0);
    tick();
    chk("rr.out_valid", out_valid, 0);
    chk("rr.op2", op2, 0);
    chk("rr.wen", wen, 0);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
